freq_bcd_display: RTL and testbench

- Downstream consumer of freq_counter. Periodically samples its 32-bit binary frequency result.
- Converts the sample to packed BCD with a sequential double-dabble engine.
- Drives a time-multiplexed, active-low 7-segment display (NUM_DIGITS digits) on the lab board.
- Flags values that do not fit in NUM_DIGITS decimal digits.

---
 rtl/freq_disp_pkg.sv | 41 ++++
 rtl/bin2bcd_seq.sv | 71 +++++++
 rtl/freq_bcd_display.sv | 120 ++++++++++++
 tb/tb_freq_bcd_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency BCD display: engine FSM states,
// double-dabble sizing and active-low 7-segment codes ordered {g,f,e,d,c,b,a}.
package freq_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int SHIFT_CYCLES       = 32;
  localparam int BCD_SCRATCH_DIGITS = 10;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 32-bit binary to 10 packed BCD digits.
// bcd_all is valid from the done pulse until the next start is accepted.
module bin2bcd_seq
  import freq_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic [39:0] bcd_all,
  output logic        busy,
  output logic        done
);

  state_t                            state_q;
  logic [31:0]                       bin_q;
  logic [4*BCD_SCRATCH_DIGITS-1:0]   scratch_q;
  logic [4*BCD_SCRATCH_DIGITS-1:0]   scratch_adj_d;
  logic [4:0]                        cnt_q;
  logic                              busy_q;
  logic                              done_q;

  for (genvar gi = 0; gi < BCD_SCRATCH_DIGITS; gi++) begin : g_adj
    assign scratch_adj_d[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                      scratch_q[4*gi +: 4] + 4'd3 :
                                      scratch_q[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q     <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjust then shift the combined {scratch, binary} register left by one.
          {scratch_q, bin_q} <= {scratch_adj_d[4*BCD_SCRATCH_DIGITS-2:0], bin_q, 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(SHIFT_CYCLES - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_all = scratch_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: rtl/freq_bcd_display.sv
// Periodically converts freq to BCD and scans it onto an active-low 7-segment
// display. Define FREQ_DISP_BLANK_EN to blank leading zeros (digit 0 always shown).
module freq_bcd_display
  import freq_disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int UPDATE_CYCLES = 50_000_000,
  parameter int DIGIT_CYCLES  = 100_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             freq,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    busy,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int UPD_W  = $clog2(UPDATE_CYCLES);
  localparam int SCAN_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [UPD_W-1:0]        upd_cnt_q;
  logic                    start;
  logic [39:0]             bcd_all;
  logic                    eng_busy;
  logic                    eng_done;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic                    ovf_q;
  logic [SCAN_W-1:0]       scan_cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_q;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   keep;
  logic [6:0]              digit_seg [NUM_DIGITS];

  assign start = (upd_cnt_q == UPD_W'(UPDATE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      upd_cnt_q <= '0;
    end else begin
      upd_cnt_q <= upd_cnt_q + 1'b1;
    end
  end

  bin2bcd_seq u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (freq),
    .bcd_all (bcd_all),
    .busy    (eng_busy),
    .done    (eng_done)
  );

  // The commit into bcd_q happens on the cycle after the engine's DONE state,
  // so busy spans the engine run plus that commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (eng_done) begin
      bcd_q <= bcd_all[4*NUM_DIGITS-1:0];
      ovf_q <= |bcd_all[39:4*NUM_DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SCAN_W'(DIGIT_CYCLES - 1)) begin
      scan_cnt_q <= '0;
      idx_q      <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
`ifdef FREQ_DISP_BLANK_EN
    if (gi == 0) begin : g_lsd
      assign keep[gi] = 1'b1;
    end else begin : g_upper
      assign keep[gi] = |bcd_q[4*NUM_DIGITS-1:4*gi];
    end
`else
    assign keep[gi] = 1'b1;
`endif
    assign digit_seg[gi] = ovf_q    ? SEG_DASH :
                           keep[gi] ? seg_encode(bcd_q[4*gi +: 4]) : SEG_BLANK;
  end

  always_comb begin
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    seg_d       = digit_seg[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign busy = eng_busy | eng_done;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_freq_bcd_display.sv
// Directed bench for freq_bcd_display (NUM_DIGITS=8, UPDATE_CYCLES=64, DIGIT_CYCLES=4).
module tb_freq_bcd_display;

  localparam int ND = 8;
  localparam int UC = 64;
  localparam int DC = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] freq = 32'd0;
  logic [31:0] bcd;
  logic        ovf;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  freq_bcd_display #(
    .NUM_DIGITS    (ND),
    .UPDATE_CYCLES (UC),
    .DIGIT_CYCLES  (DC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .freq (freq),
    .bcd  (bcd),
    .ovf  (ovf),
    .busy (busy),
    .an   (an),
    .seg  (seg)
  );

  typedef struct packed {
    logic [31:0] freq;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] b, input logic o, input int i);
    if (o) return 7'b0111111;
`ifdef FREQ_DISP_BLANK_EN
    if (i > 0 && (b >> (4*i)) == 32'd0) return 7'b1111111;
`endif
    return digit_code(b[4*i +: 4]);
  endfunction

  // Called at a negedge; returns at the first negedge where busy == val.
  task automatic wait_busy(input logic val, input int limit, input string name);
    int k = 0;
    while (busy !== val && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy !== val) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: busy=%b, expected %b within %0d cycles", name, busy, val, limit);
    end
  endtask

  task automatic run_vector(input int n, input vec_t v);
    int seen [8];
    int idx;
    foreach (seen[i]) seen[i] = 0;
    wait_busy(1'b0, 200, $sformatf("v%0d/idle", n));
    freq = v.freq;
    wait_busy(1'b1, 200, $sformatf("v%0d/start", n));
    repeat (33) @(negedge clk);
    check($sformatf("v%0d/busy_c33", n), {31'd0, busy}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d/busy_c34", n), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d/bcd", n), bcd, v.bcd);
    check($sformatf("v%0d/ovf", n), {31'd0, ovf}, {31'd0, v.ovf});
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) idx = i;
      if ($countones(~an) != 1) begin
        check($sformatf("v%0d/an_onehot", n), {24'd0, an}, 32'hFFFF_FFFF);
      end else begin
        seen[idx]++;
        check($sformatf("v%0d/seg_d%0d", n, idx), {25'd0, seg},
              {25'd0, exp_seg(v.bcd, v.ovf, idx)});
      end
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d/dwell_d%0d", n, i), seen[i], DC);
    end
  endtask

  initial begin
    vecs[0] = '{32'd12345678,  32'h12345678, 1'b0};
    vecs[1] = '{32'd100000000, 32'h00000000, 1'b1};
    vecs[2] = '{32'd99999999,  32'h99999999, 1'b0};
    vecs[3] = '{32'd0,         32'h00000000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h94967295, 1'b1};
    vecs[5] = '{32'd7,         32'h00000007, 1'b0};

    // Reset state and first start timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/an",   {24'd0, an},   32'h000000FF);
    check("rst/seg",  {25'd0, seg},  32'h0000007F);
    check("rst/bcd",  bcd,           32'd0);
    check("rst/ovf",  {31'd0, ovf},  32'd0);
    check("rst/busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (UC - 1) @(negedge clk);
    check("first_start/busy_c63", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("first_start/busy_c64", {31'd0, busy}, 32'd1);

    for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

    // freq changes while converting must not disturb the captured value.
    wait_busy(1'b0, 200, "hold/idle");
    freq = 32'd4321;
    wait_busy(1'b1, 200, "hold/start");
    freq = 32'd9999;
    repeat (34) @(negedge clk);
    check("hold/bcd_first", bcd, 32'h00004321);
    wait_busy(1'b1, 200, "hold/start2");
    repeat (34) @(negedge clk);
    check("hold/bcd_next", bcd, 32'h00009999);

    // Reset in the middle of SHIFT.
    wait_busy(1'b0, 200, "midrst/idle");
    freq = 32'd555;
    wait_busy(1'b1, 200, "midrst/start");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/busy", {31'd0, busy}, 32'd0);
    check("midrst/bcd",  bcd,           32'd0);
    check("midrst/an",   {24'd0, an},   32'h000000FF);
    check("midrst/seg",  {25'd0, seg},  32'h0000007F);
    rst = 1'b0;
    repeat (UC - 1) @(negedge clk);
    check("midrst/busy_c63", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("midrst/busy_c64", {31'd0, busy}, 32'd1);
    repeat (34) @(negedge clk);
    check("midrst/bcd_after", bcd,          32'h00000555);
    check("midrst/ovf_after", {31'd0, ovf}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
